// File: rtl/cbus_sram_responder.sv
// cbus_sram_responder
//   Memory-side end of the CBus. Accepts one request at a time, waits LATENCY
//   cycles, then streams len+1 response beats from a 64-bit internal SRAM,
//   with INCR or FIXED addressing. A one-cycle turnaround follows every
//   completed transaction.
//
// Ports
//   clk    clock
//   reset  synchronous reset, active low
//   req    request from the initiator (valid, is_write, size, addr, strobe, data, len, burst)
//   resp   ready/last/data beats back to the initiator
//   err    pulses with the last beat of an out-of-range transaction
//   busy   high whenever the responder is not idle

package cbus_pkg;

    typedef enum logic {
        BURST_FIXED = 1'b0,
        BURST_INCR  = 1'b1
    } cbus_burst_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
        cbus_burst_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

module cbus_sram_responder
    import cbus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  req,
    output cbus_resp_t resp,
    output logic       err,
    output logic       busy
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [63:0] ADDR_END  = ADDR_BASE + 64'(MEM_WORDS) * 64'd8;
    localparam logic [3:0]  WCNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        TURN
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]    wcnt;
    logic [3:0]    beat;
    logic [3:0]    len_q;
    logic          is_write_q;
    logic          incr_q;
    logic          oor_q;
    logic [AW-1:0] idx0_q;

    logic [63:0]   mem [MEM_WORDS];

    logic [63:0]   offset;
    logic          req_oor;
    logic [AW+3:0] idx_sum;
    logic [AW-1:0] idx;
    logic          beat_fire;
    logic          last_fire;
    logic          mem_we;
    logic          unused_bits;

    assign offset  = req.addr - ADDR_BASE;
    assign req_oor = (req.addr < ADDR_BASE) || (req.addr >= ADDR_END);

    // Summing in a wider field and truncating gives the modulo-MEM_WORDS wrap.
    assign idx_sum = {4'd0, idx0_q} + {{AW{1'b0}}, beat};
    assign idx     = incr_q ? idx_sum[AW-1:0] : idx0_q;

    // A beat only happens while the initiator still holds valid; dropping
    // valid mid-burst aborts without a beat in that cycle.
    assign beat_fire = (state == BURST) && req.valid;
    assign last_fire = beat_fire && (beat == len_q);
    assign mem_we    = beat_fire && is_write_q && !oor_q && reset;

    // size is not decoded and the byte offset/upper offset bits are irrelevant.
    assign unused_bits = ^{req.size, offset[2:0], offset[63:AW+3]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wcnt       <= '0;
            beat       <= '0;
            len_q      <= '0;
            is_write_q <= 1'b0;
            incr_q     <= 1'b0;
            oor_q      <= 1'b0;
            idx0_q     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req.valid) begin
                idx0_q     <= offset[AW+2:3];
                oor_q      <= req_oor;
                is_write_q <= req.is_write;
                incr_q     <= (req.burst == BURST_INCR);
                len_q      <= req.len;
                wcnt       <= WCNT_INIT;
                beat       <= '0;
            end
            if (state == WAIT && wcnt != '0) begin
                wcnt <= wcnt - 4'd1;
            end
            if (beat_fire && !last_fire) begin
                beat <= beat + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (req.strobe[i]) begin
                    mem[idx][8*i +: 8] <= req.data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        resp       = '0;
        err        = 1'b0;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (req.valid) begin
                    state_next = (LATENCY > 0) ? WAIT : BURST;
                end
            end
            WAIT: begin
                if (!req.valid) begin
                    state_next = IDLE;
                end else if (wcnt == '0) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (!req.valid) begin
                    state_next = IDLE;
                end else begin
                    resp.ready = 1'b1;
                    if (!is_write_q && !oor_q) begin
                        resp.data = mem[idx];
                    end
                    if (beat == len_q) begin
                        resp.last  = 1'b1;
                        err        = oor_q;
                        state_next = TURN;
                    end
                end
            end
            TURN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
